// File: rtl/button_debounce_if.sv
// Pin-level bundle for button_debounce: raw button in, debounced level and event pulses out.
// "release" is a reserved word in SystemVerilog, so that pulse is carried as release_pulse.
interface button_debounce_if;
  logic btn;
  logic level;
  logic press;
  logic release_pulse;
  logic long_press;

  modport master (
    output btn,
    input  level,
    input  press,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  btn,
    output level,
    output press,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/button_debounce.sv
// Pushbutton debouncer: 2-flop synchronizer, four-state debounce FSM, press/release pulses.
// Optional long-press detector enabled by defining BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
  parameter int clk_freq_hz = 100_000_000,
  parameter int debounce_ms = 10,
  parameter int long_ms     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  button_debounce_if.slave bus
);

  localparam int DB_RAW      = (clk_freq_hz / 1000) * debounce_ms;
  localparam int DB_CYCLES   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int LONG_RAW    = (clk_freq_hz / 1000) * long_ms;
  localparam int LONG_CYCLES = (LONG_RAW < 1) ? 1 : LONG_RAW;
  localparam int MAX_CYCLES  = (DB_CYCLES > LONG_CYCLES) ? DB_CYCLES : LONG_CYCLES;
  localparam int CW          = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  logic [1:0]    sync_reg;
  logic          btn_s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, press_reg, release_reg;
  logic          level_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.btn};
    end
  end

  assign btn_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RELEASED;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= level_next & ~level_reg;
      release_reg <= ~level_next & level_reg;
    end
  end

  // Every state change clears the stability counter; pending states count agreeing samples.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RELEASED: begin
        if (btn_s) begin
          state_next = PRESS_PEND;
          cnt_next   = '0;
        end
      end
      PRESS_PEND: begin
        if (!btn_s) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_PEND;
          cnt_next   = '0;
        end
      end
      RELEASE_PEND: begin
        if (btn_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = RELEASED;
          cnt_next   = '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
  end

  // Registered from the next state so level tracks PRESSED/RELEASE_PEND without an extra cycle.
  assign level_next = (state_next == PRESSED) || (state_next == RELEASE_PEND);

  assign bus.level         = level_reg;
  assign bus.press         = press_reg;
  assign bus.release_pulse = release_reg;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_CYCLES);

  logic [CW-1:0] hold_reg, hold_next;
  logic          long_reg, long_next;

  // Hold count parks at LONG_CYCLES after firing, so a bounce back into PRESSED cannot re-fire.
  always_comb begin
    hold_next = hold_reg;
    long_next = 1'b0;
    if ((state_reg == PRESS_PEND) && (state_next == PRESSED)) begin
      hold_next = '0;
    end else if (state_reg == PRESSED) begin
      if (hold_reg == LONG_LAST) begin
        long_next = 1'b1;
      end
      if (hold_reg != LONG_SAT) begin
        hold_next = hold_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg <= '0;
      long_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
      long_reg <= long_next;
    end
  end

  assign bus.long_press = long_reg;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized + directed bench for button_debounce against a run-length reference model.
module tb_button_debounce;

  localparam int CLK_HZ  = 4000;
  localparam int DB_MS   = 2;
  localparam int LONG_MS = 10;
  localparam int DB      = 8;
  localparam int LONG    = 40;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  button_debounce_if bus ();

  button_debounce #(
    .clk_freq_hz (CLK_HZ),
    .debounce_ms (DB_MS),
    .long_ms     (LONG_MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the debounced value flips once DB+1 consecutive synchronized samples disagree with it.
  bit hist[$];
  int m_run;
  int m_hold;
  bit m_deb, m_press, m_rel, m_long;

  task automatic model_reset();
    hist    = '{1'b0, 1'b0};
    m_run   = 0;
    m_hold  = 0;
    m_deb   = 1'b0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
  endtask

  task automatic model_step();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hist.push_back(bus.btn);
    s       = hist.pop_front();
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (m_deb && m_run == 0) begin
      if (LONG_EN && m_hold == LONG - 1) m_long = 1'b1;
      if (m_hold < LONG) m_hold++;
    end
    if (s != m_deb) m_run++;
    else            m_run = 0;
    if (m_run == DB + 1) begin
      m_deb = ~m_deb;
      m_run = 0;
      if (m_deb) begin
        m_press = 1'b1;
        m_hold  = 0;
      end else begin
        m_rel = 1'b1;
      end
    end
  endtask

  int cyc, press_at, rel_at, long_at, rise_at, fall_at, n_press, n_rel, n_long;
  logic prev_level;

  task automatic open_window();
    cyc      = 0;
    press_at = -1;
    rel_at   = -1;
    long_at  = -1;
    rise_at  = -1;
    fall_at  = -1;
    n_press  = 0;
    n_rel    = 0;
    n_long   = 0;
    prev_level = bus.level;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("level", bus.level, m_deb);
    check("press", bus.press, m_press);
    check("release", bus.release_pulse, m_rel);
    check("long_press", bus.long_press, m_long);
    check("one_pulse", (int'(bus.press) + int'(bus.release_pulse) + int'(bus.long_press)) <= 1, 1);
    cyc++;
    if (bus.press === 1'b1) begin
      n_press++;
      if (press_at < 0) press_at = cyc;
    end
    if (bus.release_pulse === 1'b1) begin
      n_rel++;
      if (rel_at < 0) rel_at = cyc;
    end
    if (bus.long_press === 1'b1) begin
      n_long++;
      if (long_at < 0) long_at = cyc;
    end
    if (bus.level === 1'b1 && prev_level === 1'b0 && rise_at < 0) rise_at = cyc;
    if (bus.level === 1'b0 && prev_level === 1'b1 && fall_at < 0) fall_at = cyc;
    prev_level = bus.level;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_press"}, bus.press, 0);
    check({tag, "_release"}, bus.release_pulse, 0);
    check({tag, "_long"}, bus.long_press, 0);
  endtask

  task automatic drive(input bit v, input int n);
    bus.btn = v;
    repeat (n) tick();
  endtask

  initial begin
    int r, dur;
    bus.btn = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    check_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (12) tick();

    // Clean press, held long enough to cover the long-press point.
    open_window();
    drive(1'b1, 100);
    check("clean_press_at", press_at, 11);
    check("clean_level_at", rise_at, 11);
    check("clean_n_press", n_press, 1);
    check("clean_n_release", n_rel, 0);
    check("long_at", long_at, LONG_EN ? 51 : -1);
    check("long_count", n_long, LONG_EN ? 1 : 0);
    $display("[TB] clean_press: press_at=%0d level_at=%0d long_at=%0d", press_at, rise_at, long_at);

    // Clean release.
    open_window();
    drive(1'b0, 20);
    check("rel_at", rel_at, 11);
    check("rel_level_at", fall_at, 11);
    check("rel_n_press", n_press, 0);
    $display("[TB] clean_release: release_at=%0d level_fall_at=%0d", rel_at, fall_at);

    // Release with a 3-cycle high glitch mid-pend: count restarts from the final fall.
    drive(1'b1, 30);
    open_window();
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 25);
    check("glitch_rel_at", rel_at, 18);
    check("glitch_n_rel", n_rel, 1);
    check("glitch_n_press", n_press, 0);
    $display("[TB] glitch_release: release_at=%0d", rel_at);

    // Bouncy press: 5 high, 2 low, 20 high.
    open_window();
    drive(1'b1, 5);
    drive(1'b0, 2);
    drive(1'b1, 20);
    check("bounce_press_at", press_at, 18);
    check("bounce_n_press", n_press, 1);
    check("bounce_n_rel", n_rel, 0);
    $display("[TB] bounce_press: press_at=%0d n_press=%0d", press_at, n_press);

    // Reset in the middle of a press debounce with the button held.
    drive(1'b0, 15);
    open_window();
    drive(1'b1, 6);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    open_window();
    repeat (15) tick();
    check("rst_press_at", press_at, 11);
    check("rst_n_press", n_press, 1);
    $display("[TB] reset_mid_pend: press_at=%0d n_press=%0d", press_at, n_press);

    // Random segments: short bounces, long holds, occasional resets.
    repeat (300) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rand_rst");
        repeat (int'($urandom_range(1, 4))) tick();
        rst_n = 1'b1;
      end else begin
        dur = (r < 20) ? int'($urandom_range(1, 9)) : int'($urandom_range(9, 70));
        drive(bit'($urandom_range(0, 1)), dur);
      end
    end
    $display("[TB] random_phase: done at t=%0t", $time);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
